// File: rtl/gprmc_pkg.sv
// Shared constants, state encoding and helpers for the NMEA GPRMC sentence path.
package gprmc_pkg;

    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_COMMA  = 8'h2C;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_CR     = 8'h0D;
    localparam logic [7:0] ASCII_LF     = 8'h0A;
    localparam logic [7:0] ASCII_A      = 8'h41;
    localparam logic [7:0] ASCII_V      = 8'h56;
    localparam logic [7:0] ASCII_N      = 8'h4E;
    localparam logic [7:0] ASCII_S      = 8'h53;
    localparam logic [7:0] ASCII_E      = 8'h45;
    localparam logic [7:0] ASCII_W      = 8'h57;

    // Talker + sentence id including the trailing comma, first char in the MSBs.
    localparam logic [47:0] GPRMC_HDR = 48'h4750_524D_432C;

    localparam int SENTENCE_LEN = 53;
    localparam int BODY_LAST    = 47;
    localparam int IDX_W        = $clog2(SENTENCE_LEN);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BODY  = 3'd1,
        ST_STAR  = 3'd2,
        ST_CS_HI = 3'd3,
        ST_CS_LO = 3'd4,
        ST_CR    = 3'd5,
        ST_LF    = 3'd6
    } state_t;

    // Map a 4-bit nibble to its uppercase ASCII hex digit.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end else begin
            return 8'h37 + {4'h0, nib};
        end
    endfunction

endpackage

// File: rtl/nmea_checksum_acc.sv
// Running 8-bit XOR over NMEA sentence bytes; shared by the tx and rx paths.
module nmea_checksum_acc (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] csum
);

    // Accumulate the XOR of every enabled byte; clear wins over enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= 8'h00;
        end else if (clear) begin
            csum <= 8'h00;
        end else if (en) begin
            csum <= csum ^ data;
        end else begin
            csum <= csum;
        end
    end

endmodule

// File: rtl/gprmc_sentence_gen.sv
// Serialises a $GPRMC sentence from latched ASCII fields onto a byte handshake.
module gprmc_sentence_gen
    import gprmc_pkg::*;
#(
    parameter bit CHECKSUM_EN = 1'b1,
    parameter bit EMIT_CRLF   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        fix_valid,
    input  logic [47:0] time_ascii,
    input  logic [63:0] lat_ascii,
    input  logic        lat_s,
    input  logic [63:0] lon_ascii,
    input  logic        lon_w,
    input  logic [47:0] spd_ascii,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    state_t             state_r;
    logic [IDX_W-1:0]   idx_r;
    logic               fix_r;
    logic [47:0]        time_r;
    logic [63:0]        lat_r;
    logic               lat_south_r;
    logic [63:0]        lon_r;
    logic               lon_west_r;
    logic [47:0]        spd_r;

    logic [383:0]       body_s;
    logic [383:0]       body_shift_s;
    logic [IDX_W-1:0]   idx_next_s;
    logic [7:0]         body_byte_s;
    logic               xfer_s;
    logic               csum_clr_s;
    logic               csum_en_s;
    logic [7:0]         csum_s;

    // Indices 0..47 as one flat vector, byte 0 in the MSBs.
    assign body_s = {ASCII_DOLLAR, GPRMC_HDR, time_r, ASCII_COMMA,
                     (fix_r ? ASCII_A : ASCII_V), ASCII_COMMA,
                     lat_r, ASCII_COMMA, (lat_south_r ? ASCII_S : ASCII_N), ASCII_COMMA,
                     lon_r, ASCII_COMMA, (lon_west_r ? ASCII_W : ASCII_E), ASCII_COMMA,
                     spd_r, ASCII_COMMA, ASCII_COMMA, ASCII_COMMA, ASCII_COMMA};

    assign idx_next_s   = idx_r + 6'd1;
    assign body_shift_s = body_s << {idx_next_s, 3'b000};
    assign body_byte_s  = body_shift_s[383:376];
    assign xfer_s       = tx_valid & tx_ready;
    assign csum_clr_s   = start & (state_r == ST_IDLE);
    // '$' (index 0) is excluded; only BODY bytes 1..47 feed the checksum.
    assign csum_en_s    = xfer_s & (state_r == ST_BODY) & (idx_r != 6'd0);

    nmea_checksum_acc u_csum (
        .clk   (clk),
        .rst   (rst),
        .clear (csum_clr_s),
        .en    (csum_en_s),
        .data  (tx_data),
        .csum  (csum_s)
    );

    // Sentence FSM: latch fields on start, present the next byte after each transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= 6'd0;
            tx_data     <= 8'h00;
            tx_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fix_r       <= 1'b0;
            time_r      <= 48'h0;
            lat_r       <= 64'h0;
            lat_south_r <= 1'b0;
            lon_r       <= 64'h0;
            lon_west_r  <= 1'b0;
            spd_r       <= 48'h0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        fix_r       <= fix_valid;
                        time_r      <= time_ascii;
                        lat_r       <= lat_ascii;
                        lat_south_r <= lat_s;
                        lon_r       <= lon_ascii;
                        lon_west_r  <= lon_w;
                        spd_r       <= spd_ascii;
                        idx_r       <= 6'd0;
                        tx_data     <= ASCII_DOLLAR;
                        tx_valid    <= 1'b1;
                        busy        <= 1'b1;
                        state_r     <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (xfer_s) begin
                        idx_r <= idx_next_s;
                        if (idx_r != 6'(BODY_LAST)) begin
                            tx_data <= body_byte_s;
                        end else if (CHECKSUM_EN) begin
                            tx_data <= ASCII_STAR;
                            state_r <= ST_STAR;
                        end else if (EMIT_CRLF) begin
                            tx_data <= ASCII_CR;
                            state_r <= ST_CR;
                        end else begin
                            idx_r    <= 6'd0;
                            tx_data  <= 8'h00;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state_r  <= ST_IDLE;
                        end
                    end
                end
                ST_STAR: begin
                    if (xfer_s) begin
                        idx_r   <= idx_next_s;
                        tx_data <= hex_char(csum_s[7:4]);
                        state_r <= ST_CS_HI;
                    end
                end
                ST_CS_HI: begin
                    if (xfer_s) begin
                        idx_r   <= idx_next_s;
                        tx_data <= hex_char(csum_s[3:0]);
                        state_r <= ST_CS_LO;
                    end
                end
                ST_CS_LO: begin
                    if (xfer_s) begin
                        if (EMIT_CRLF) begin
                            idx_r   <= idx_next_s;
                            tx_data <= ASCII_CR;
                            state_r <= ST_CR;
                        end else begin
                            idx_r    <= 6'd0;
                            tx_data  <= 8'h00;
                            tx_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state_r  <= ST_IDLE;
                        end
                    end
                end
                ST_CR: begin
                    if (xfer_s) begin
                        idx_r   <= idx_next_s;
                        tx_data <= ASCII_LF;
                        state_r <= ST_LF;
                    end
                end
                ST_LF: begin
                    if (xfer_s) begin
                        idx_r    <= 6'd0;
                        tx_data  <= 8'h00;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state_r  <= ST_IDLE;
                    end
                end
                default: begin
                    idx_r    <= 6'd0;
                    tx_data  <= 8'h00;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gprmc_sentence_gen.sv
// Scoreboard bench: full-option instance (k=0) and bare instance (k=1, no checksum, no CR/LF).
module tb_gprmc_sentence_gen;

    typedef struct packed {
        logic        fix;
        logic [47:0] tm;
        logic [63:0] lat;
        logic        ns;
        logic [63:0] lon;
        logic        ew;
        logic [47:0] spd;
    } fields_t;

    typedef logic [7:0] bq_t [$];

    logic        clk = 1'b0;
    logic        rst;
    logic        start_0, start_1;
    logic        fix_valid, lat_s, lon_w;
    logic [47:0] time_ascii, spd_ascii;
    logic [63:0] lat_ascii, lon_ascii;
    logic        rdy_0, rdy_1;
    logic [7:0]  tx_data_0, tx_data_1;
    logic        tx_valid_0, tx_valid_1, busy_0, busy_1, done_0, done_1;

    logic [7:0]  exp_q [2][$];
    logic [7:0]  data_a [2];
    logic        valid_a [2], ready_a [2], busy_a [2], done_a [2];
    logic        held [2];
    logic [7:0]  held_data [2];
    logic        pend_done [2];
    int          done_cnt [2];
    int          nbytes [2];
    int          rdy_mode [2];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    gprmc_sentence_gen #(.CHECKSUM_EN(1'b1), .EMIT_CRLF(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start_0), .fix_valid(fix_valid),
        .time_ascii(time_ascii), .lat_ascii(lat_ascii), .lat_s(lat_s),
        .lon_ascii(lon_ascii), .lon_w(lon_w), .spd_ascii(spd_ascii),
        .tx_data(tx_data_0), .tx_valid(tx_valid_0), .tx_ready(rdy_0),
        .busy(busy_0), .done(done_0));

    gprmc_sentence_gen #(.CHECKSUM_EN(1'b0), .EMIT_CRLF(1'b0)) dut_bare (
        .clk(clk), .rst(rst), .start(start_1), .fix_valid(fix_valid),
        .time_ascii(time_ascii), .lat_ascii(lat_ascii), .lat_s(lat_s),
        .lon_ascii(lon_ascii), .lon_w(lon_w), .spd_ascii(spd_ascii),
        .tx_data(tx_data_1), .tx_valid(tx_valid_1), .tx_ready(rdy_1),
        .busy(busy_1), .done(done_1));

    assign data_a[0]  = tx_data_0;  assign data_a[1]  = tx_data_1;
    assign valid_a[0] = tx_valid_0; assign valid_a[1] = tx_valid_1;
    assign ready_a[0] = rdy_0;      assign ready_a[1] = rdy_1;
    assign busy_a[0]  = busy_0;     assign busy_a[1]  = busy_1;
    assign done_a[0]  = done_0;     assign done_a[1]  = done_1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
    endfunction

    // Reference sentence built directly from the field list and NMEA rules.
    function automatic bq_t model(input fields_t f, input bit cs_en, input bit crlf);
        bq_t   q;
        string hdr = "GPRMC,";
        logic [7:0] cs = 8'h00;
        q.push_back(8'h24);
        for (int i = 0; i < 6; i++) q.push_back(hdr[i]);
        for (int i = 0; i < 6; i++) q.push_back(f.tm[47-8*i -: 8]);
        q.push_back(8'h2C);
        q.push_back(f.fix ? 8'h41 : 8'h56);
        q.push_back(8'h2C);
        for (int i = 0; i < 8; i++) q.push_back(f.lat[63-8*i -: 8]);
        q.push_back(8'h2C);
        q.push_back(f.ns ? 8'h53 : 8'h4E);
        q.push_back(8'h2C);
        for (int i = 0; i < 8; i++) q.push_back(f.lon[63-8*i -: 8]);
        q.push_back(8'h2C);
        q.push_back(f.ew ? 8'h57 : 8'h45);
        q.push_back(8'h2C);
        for (int i = 0; i < 6; i++) q.push_back(f.spd[47-8*i -: 8]);
        for (int i = 0; i < 4; i++) q.push_back(8'h2C);
        if (cs_en) begin
            for (int i = 1; i < q.size(); i++) cs ^= q[i];
            q.push_back(8'h2A);
            q.push_back(hexc(cs[7:4]));
            q.push_back(hexc(cs[3:0]));
        end
        if (crlf) begin
            q.push_back(8'h0D);
            q.push_back(8'h0A);
        end
        return q;
    endfunction

    function automatic bq_t from_str(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    function automatic fields_t rand_fields();
        fields_t f;
        f.fix = 1'($urandom_range(0, 1));
        f.ns  = 1'($urandom_range(0, 1));
        f.ew  = 1'($urandom_range(0, 1));
        f.tm  = {16'($urandom), $urandom};
        f.lat = {$urandom, $urandom};
        f.lon = {$urandom, $urandom};
        f.spd = {16'($urandom), $urandom};
        return f;
    endfunction

    task automatic set_fields(input fields_t f);
        fix_valid  = f.fix;  time_ascii = f.tm;  lat_ascii = f.lat; lat_s = f.ns;
        lon_ascii  = f.lon;  lon_w      = f.ew;  spd_ascii = f.spd;
    endtask

    // Queue the expected bytes, then pulse start for one clock.
    task automatic send(input int k, input fields_t f, input bq_t exp);
        @(posedge clk); #1;
        set_fields(f);
        foreach (exp[i]) exp_q[k].push_back(exp[i]);
        if (k == 0) start_0 = 1'b1; else start_1 = 1'b1;
        @(posedge clk); #1;
        start_0 = 1'b0;
        start_1 = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, input string name, output int cycles);
        int base = done_cnt[k];
        cycles = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk); #1;
            if (done_cnt[k] != base) begin
                cycles = c;
                break;
            end
        end
        chk(cycles > 0, {name, "_done_timeout"}, 32'(cycles), 32'(budget));
        chk(exp_q[k].size() == 0, {name, "_bytes_missing"}, 32'(exp_q[k].size()), 32'd0);
    endtask

    // Ready driver: held high or randomly toggled per instance.
    always @(posedge clk) begin
        #1;
        rdy_0 = (rdy_mode[0] != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        rdy_1 = (rdy_mode[1] != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic mon_step(input int k);
        logic [7:0] e;
        if (rst) begin
            held[k]      = 1'b0;
            pend_done[k] = 1'b0;
        end else begin
            if (pend_done[k] || done_a[k]) begin
                chk(done_a[k] == pend_done[k] && !(pend_done[k] && busy_a[k]),
                    $sformatf("done_pulse_%0d", k), {30'd0, busy_a[k], done_a[k]}, {31'd0, pend_done[k]});
                if (done_a[k]) done_cnt[k]++;
                pend_done[k] = 1'b0;
            end
            if (held[k]) begin
                chk(valid_a[k] && data_a[k] == held_data[k], $sformatf("stall_hold_%0d", k),
                    {23'd0, valid_a[k], data_a[k]}, {24'd1, held_data[k]});
            end
            held[k] = 1'b0;
            if (valid_a[k] && ready_a[k]) begin
                if (exp_q[k].size() == 0) begin
                    chk(exp_q[k].size() != 0, $sformatf("extra_byte_%0d", k), 32'(data_a[k]), 32'd0);
                end else begin
                    e = exp_q[k].pop_front();
                    chk(data_a[k] == e, $sformatf("byte_%0d_n%0d", k, nbytes[k]), 32'(data_a[k]), 32'(e));
                    nbytes[k]++;
                    if (exp_q[k].size() == 0) pend_done[k] = 1'b1;
                end
            end else if (valid_a[k]) begin
                held[k]      = 1'b1;
                held_data[k] = data_a[k];
            end
        end
    endtask

    // Monitor: sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) mon_step(k);
    end

    initial begin
        fields_t zf, fa, fb;
        int      cyc, base, d;
        string   s1, s2;
        s1 = "$GPRMC,000000,V,00000000,N,00000000,E,000000,,,,*3A\r\n";
        s2 = "$GPRMC,000000,A,00000000,N,00000000,E,000000,,,,*2D\r\n";
        for (int k = 0; k < 2; k++) begin
            held[k] = 1'b0; pend_done[k] = 1'b0; done_cnt[k] = 0; nbytes[k] = 0; rdy_mode[k] = 0;
        end
        rst = 1'b1; start_0 = 1'b0; start_1 = 1'b0; rdy_0 = 1'b1; rdy_1 = 1'b1;
        zf = '{fix: 1'b0, tm: {6{8'h30}}, lat: {8{8'h30}}, ns: 1'b0, lon: {8{8'h30}}, ew: 1'b0, spd: {6{8'h30}}};
        set_fields(zf);
        #12;
        chk(tx_valid_0 == 1'b0 && busy_0 == 1'b0 && done_0 == 1'b0, "reset_ctrl", {29'd0, tx_valid_0, busy_0, done_0}, 32'd0);
        chk(tx_data_0 == 8'h00, "reset_data", 32'(tx_data_0), 32'd0);
        chk(tx_valid_1 == 1'b0 && busy_1 == 1'b0 && tx_data_1 == 8'h00, "reset_bare", {23'd0, tx_valid_1, tx_data_1}, 32'd0);
        @(posedge clk); #1; rst = 1'b0;

        // 1: all-zero fields, void fix, ready held high: 53 bytes back to back
        send(0, zf, from_str(s1));
        wait_done(0, 200, "t1", cyc);
        chk(cyc == 54, "t1_cycles", 32'(cyc), 32'd54);

        // 2: valid fix
        zf.fix = 1'b1;
        send(0, zf, from_str(s2));
        wait_done(0, 200, "t2", cyc);
        zf.fix = 1'b0;

        // 3: random back-pressure, same sentence as test 1
        rdy_mode[0] = 1;
        send(0, zf, from_str(s1));
        wait_done(0, 600, "t3", cyc);
        for (int n = 0; n < 4; n++) begin
            fa = rand_fields();
            send(0, fa, model(fa, 1'b1, 1'b1));
            wait_done(0, 600, "t3r", cyc);
        end
        rdy_mode[0] = 0;

        // 4: start re-pulsed mid-sentence with new fields is ignored
        fa = rand_fields();
        fb = rand_fields();
        base = nbytes[0];
        send(0, fa, model(fa, 1'b1, 1'b1));
        for (int c = 0; c < 100 && nbytes[0] - base < 20; c++) @(posedge clk);
        #1;
        chk(busy_0 == 1'b1, "t4_busy_mid", 32'(busy_0), 32'd1);
        set_fields(fb);
        start_0 = 1'b1;
        @(posedge clk); #1;
        start_0 = 1'b0;
        wait_done(0, 200, "t4", cyc);
        repeat (3) @(posedge clk);
        chk(busy_0 == 1'b0 && tx_valid_0 == 1'b0, "t4_no_restart", {30'd0, busy_0, tx_valid_0}, 32'd0);

        // 5: reset mid-sentence aborts, then a full sentence follows
        fa = rand_fields();
        base = nbytes[0];
        send(0, fa, model(fa, 1'b1, 1'b1));
        for (int c = 0; c < 100 && nbytes[0] - base < 30; c++) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk(tx_valid_0 == 1'b0, "t5_valid_async", 32'(tx_valid_0), 32'd0);
        chk(busy_0 == 1'b0, "t5_busy_async", 32'(busy_0), 32'd0);
        exp_q[0].delete();
        d = done_cnt[0];
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        repeat (5) @(posedge clk);
        chk(done_cnt[0] == d, "t5_no_done", 32'(done_cnt[0]), 32'(d));
        fb = rand_fields();
        send(0, fb, model(fb, 1'b1, 1'b1));
        wait_done(0, 200, "t5", cyc);

        // 6: no checksum, no terminator: 48 bytes ending with ','
        send(1, zf, model(zf, 1'b0, 1'b0));
        wait_done(1, 200, "t6", cyc);
        chk(cyc == 49, "t6_cycles", 32'(cyc), 32'd49);
        rdy_mode[1] = 1;
        for (int n = 0; n < 3; n++) begin
            fa = rand_fields();
            send(1, fa, model(fa, 1'b0, 1'b0));
            wait_done(1, 500, "t6r", cyc);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
